sensor_word_checker: RTL and testbench

Receive-side framing stage for Sensirion-style I2C sensor reads. Consumes the byte stream produced by the I2C master during a read, groups it into words of two data bytes plus one CRC byte, and computes CRC-8 (poly 0x31, init 0xFF, MSB-first, no final XOR) over the data bytes with an internal bit-serial engine. Each received CRC byte is checked against the computed value. The block emits the 16-bit word with a pass/fail flag and counts failures.

---
 rtl/sensor_word_checker_pkg.sv | 24 ++
 rtl/sensor_word_checker_if.sv | 29 ++
 rtl/sensor_word_checker_crc8_step.sv | 15 +
 rtl/sensor_word_checker.sv | 142 ++++++++++++++
 tb/tb_sensor_word_checker.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_word_checker_pkg.sv
// Shared definitions for the sensor word checker.
// Holds the CRC defaults, the FSM state encoding and the word payload layout.
package sensor_word_checker_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned ERR_CNT_W = 8;

    localparam logic [BYTE_W-1:0] POLY_DEFAULT = 8'h31;
    localparam logic [BYTE_W-1:0] INIT_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_BYTE = 2'b01,
        SHIFT     = 2'b10
    } state_e;

    // Received word: first data byte on the wire lands in the upper half.
    typedef struct packed {
        logic [BYTE_W-1:0] data_hi;
        logic [BYTE_W-1:0] data_lo;
    } word_t;

endpackage

// File: rtl/sensor_word_checker_if.sv
// Byte-in / word-out bus of the sensor word checker.
//   master: drives start, byte_valid, byte_in; observes the rest
//   slave : the checker itself
interface sensor_word_checker_if;
    import sensor_word_checker_pkg::*;

    logic                 start;
    logic                 byte_valid;
    logic [BYTE_W-1:0]    byte_in;
    logic                 byte_ready;
    logic                 word_valid;
    word_t                word_data;
    logic                 word_crc_ok;
    logic                 frame_done;
    logic                 busy;
    logic [ERR_CNT_W-1:0] crc_err_cnt;

    modport master (
        output start, byte_valid, byte_in,
        input  byte_ready, word_valid, word_data, word_crc_ok,
               frame_done, busy, crc_err_cnt
    );

    modport slave (
        input  start, byte_valid, byte_in,
        output byte_ready, word_valid, word_data, word_crc_ok,
               frame_done, busy, crc_err_cnt
    );
endinterface

// File: rtl/sensor_word_checker_crc8_step.sv
// One MSB-first bit step of a CRC-8 LFSR.
//   crc_in  : current remainder
//   poly    : generator polynomial (implicit x^8)
//   crc_out : remainder after shifting one bit
module crc8_step
    import sensor_word_checker_pkg::*;
(
    input  logic [BYTE_W-1:0] crc_in,
    input  logic [BYTE_W-1:0] poly,
    output logic [BYTE_W-1:0] crc_out
);
    always_comb begin
        crc_out = {crc_in[BYTE_W-2:0], 1'b0} ^ (crc_in[BYTE_W-1] ? poly : '0);
    end
endmodule

// File: rtl/sensor_word_checker.sv
// Receive-side framing stage for Sensirion-style I2C sensor reads.
// Groups the incoming byte stream into {data, data, crc} words, runs a
// bit-serial CRC-8 over the two data bytes and flags each word pass/fail.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of sensor_word_checker_if (byte in, word out)
module sensor_word_checker
    import sensor_word_checker_pkg::*;
#(
    parameter int unsigned       WORDS = 2,
    parameter logic [BYTE_W-1:0] POLY  = POLY_DEFAULT,
    parameter logic [BYTE_W-1:0] INIT  = INIT_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    sensor_word_checker_if.slave bus
);
    localparam int unsigned WORD_IDX_W = 4;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned BYTE_IDX_W = 2;

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(7);
    localparam logic [BYTE_IDX_W-1:0] CRC_IDX   = BYTE_IDX_W'(2);
    localparam logic [ERR_CNT_W-1:0]  ERR_MAX   = '1;

    state_e                 state;
    logic [BYTE_W-1:0]      crc;
    logic [BYTE_W-1:0]      crc_shift;
    logic [BYTE_IDX_W-1:0]  byte_idx;
    logic [WORD_IDX_W-1:0]  word_idx;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0]      data_hi;
    logic [BYTE_W-1:0]      data_lo;

    logic                   byte_ready_q;
    logic                   word_valid_q;
    word_t                  word_data_q;
    logic                   word_crc_ok_q;
    logic                   frame_done_q;
    logic                   busy_q;
    logic [ERR_CNT_W-1:0]   crc_err_cnt_q;

    crc8_step u_crc8_step (
        .crc_in  (crc),
        .poly    (POLY),
        .crc_out (crc_shift)
    );

    // Framing FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            crc           <= INIT;
            byte_idx      <= '0;
            word_idx      <= '0;
            bit_cnt       <= '0;
            data_hi       <= '0;
            data_lo       <= '0;
            byte_ready_q  <= 1'b0;
            word_valid_q  <= 1'b0;
            word_data_q   <= '0;
            word_crc_ok_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            crc_err_cnt_q <= '0;
        end else begin
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;

            if (bus.start) begin
                // Abort whatever is in flight; a coincident byte is dropped.
                state        <= WAIT_BYTE;
                crc          <= INIT;
                byte_idx     <= '0;
                word_idx     <= '0;
                bit_cnt      <= '0;
                byte_ready_q <= 1'b1;
                busy_q       <= 1'b1;
            end else begin
                case (state)
                    WAIT_BYTE: begin
                        if (bus.byte_valid) begin
                            if (byte_idx == CRC_IDX) begin
                                word_valid_q  <= 1'b1;
                                word_crc_ok_q <= (bus.byte_in == crc);
                                word_data_q   <= '{data_hi: data_hi, data_lo: data_lo};
                                if ((bus.byte_in != crc) && (crc_err_cnt_q != ERR_MAX)) begin
                                    crc_err_cnt_q <= crc_err_cnt_q + ERR_CNT_W'(1);
                                end
                                crc      <= INIT;
                                byte_idx <= '0;
                                word_idx <= word_idx + WORD_IDX_W'(1);
                                if (word_idx == LAST_WORD) begin
                                    frame_done_q <= 1'b1;
                                    state        <= IDLE;
                                    byte_ready_q <= 1'b0;
                                    busy_q       <= 1'b0;
                                end
                            end else begin
                                // Data byte: fold into the remainder, then 8 shift cycles.
                                crc <= crc ^ bus.byte_in;
                                if (byte_idx == '0) begin
                                    data_hi <= bus.byte_in;
                                end else begin
                                    data_lo <= bus.byte_in;
                                end
                                byte_idx     <= byte_idx + BYTE_IDX_W'(1);
                                bit_cnt      <= '0;
                                state        <= SHIFT;
                                byte_ready_q <= 1'b0;
                            end
                        end
                    end
                    SHIFT: begin
                        crc     <= crc_shift;
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state        <= WAIT_BYTE;
                            byte_ready_q <= 1'b1;
                        end
                    end
                    IDLE: begin
                    end
                    default: begin
                        state        <= IDLE;
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.byte_ready  = byte_ready_q;
    assign bus.word_valid  = word_valid_q;
    assign bus.word_data   = word_data_q;
    assign bus.word_crc_ok = word_crc_ok_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = busy_q;
    assign bus.crc_err_cnt = crc_err_cnt_q;

endmodule

// File: tb/tb_sensor_word_checker.sv
// Bench for sensor_word_checker: two instances (WORDS=1 and WORDS=2) share
// one stimulus stream and are compared every cycle against a byte-level
// reference model, plus table vectors and hand-written corner sequences.
module tb_sensor_word_checker;
    import sensor_word_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       bv = 1'b0;
    logic [7:0] bi = 8'h00;

    always #5 clk = ~clk;

    sensor_word_checker_if ifa ();
    sensor_word_checker_if ifb ();

    assign ifa.start      = start;
    assign ifa.byte_valid = bv;
    assign ifa.byte_in    = bi;
    assign ifb.start      = start;
    assign ifb.byte_valid = bv;
    assign ifb.byte_in    = bi;

    sensor_word_checker #(.WORDS(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sensor_word_checker #(.WORDS(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    // Reference model state, one slot per instance.
    int         words_cfg [2] = '{1, 2};
    bit         m_act   [2];
    int         m_block [2];
    logic [7:0] m_b     [2][3];
    int         m_n     [2];
    int         m_word  [2];
    int         m_err   [2];
    logic       e_ready [2];
    logic       e_valid [2];
    logic       e_done  [2];
    logic       e_busy  [2];
    logic       e_ok    [2];
    logic [15:0] e_data [2];
    int         vcnt    [2] = '{0, 0};

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  c;
        logic [15:0] data;
        bit          ok;
    } vec_t;

    vec_t vt [6];

    function automatic logic [7:0] crc8_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] d [2];
        c = 8'hFF;
        d[0] = a;
        d[1] = b;
        for (int i = 0; i < 2; i++) begin
            c = c ^ d[i];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_act[k] = 0; m_block[k] = 0; m_n[k] = 0; m_word[k] = 0; m_err[k] = 0;
                e_valid[k] = 0; e_done[k] = 0; e_data[k] = '0; e_ok[k] = 0;
            end else begin
                e_valid[k] = 0;
                e_done[k]  = 0;
                if (start) begin
                    m_act[k] = 1; m_block[k] = 0; m_n[k] = 0; m_word[k] = 0;
                end else if (m_act[k] && m_block[k] == 0 && bv) begin
                    m_b[k][m_n[k]] = bi;
                    m_n[k]++;
                    if (m_n[k] < 3) begin
                        m_block[k] = 8;
                    end else begin
                        e_valid[k] = 1;
                        e_data[k]  = {m_b[k][0], m_b[k][1]};
                        e_ok[k]    = (m_b[k][2] == crc8_ref(m_b[k][0], m_b[k][1]));
                        if (!e_ok[k] && m_err[k] < 255) m_err[k]++;
                        m_n[k] = 0;
                        m_word[k]++;
                        if (m_word[k] == words_cfg[k]) begin
                            m_act[k]  = 0;
                            e_done[k] = 1;
                        end
                    end
                end else if (m_block[k] > 0) begin
                    m_block[k]--;
                end
            end
            e_ready[k] = m_act[k] && (m_block[k] == 0);
            e_busy[k]  = m_act[k];
        end
    endtask

    function automatic logic [28:0] dut_vec(input int k);
        if (k == 0)
            return {ifa.byte_ready, ifa.word_valid, ifa.word_data, ifa.word_crc_ok,
                    ifa.frame_done, ifa.busy, ifa.crc_err_cnt};
        return {ifb.byte_ready, ifb.word_valid, ifb.word_data, ifb.word_crc_ok,
                ifb.frame_done, ifb.busy, ifb.crc_err_cnt};
    endfunction

    function automatic logic [28:0] model_vec(input int k);
        return {e_ready[k], e_valid[k], e_data[k], e_ok[k], e_done[k], e_busy[k], 8'(m_err[k])};
    endfunction

    // One clock: update the model at the edge, compare both instances 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cycle++;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_dut%0d", k), 64'(dut_vec(k)), 64'(model_vec(k)));
        end
        if (ifa.word_valid) vcnt[0]++;
        if (ifb.word_valid) vcnt[1]++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int k);
        bit was;
        bit got;
        got = 0;
        bv  = 1'b1;
        bi  = b;
        for (int i = 0; i < 30; i++) begin
            was = e_ready[k];
            tick();
            if (was) begin
                got = 1;
                break;
            end
        end
        bv = 1'b0;
        if (!got) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] c, input int k);
        send_byte(b0, k);
        send_byte(b1, k);
        send_byte(c, k);
    endtask

    initial begin
        int t_acc [3];
        logic [7:0] gap_bytes [3];
        int idx;
        int v0;

        vt[0] = '{8'hBE, 8'hEF, 8'h92, 16'hBEEF, 1'b1};
        vt[1] = '{8'h00, 8'h00, 8'h81, 16'h0000, 1'b1};
        vt[2] = '{8'hBE, 8'hEF, 8'h00, 16'hBEEF, 1'b0};
        vt[3] = '{8'h00, 8'h00, 8'h80, 16'h0000, 1'b0};
        vt[4] = '{8'hBE, 8'hEF, 8'hFF, 16'hBEEF, 1'b0};
        vt[5] = '{8'h00, 8'h00, 8'h81, 16'h0000, 1'b1};

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("reset_state", 64'(dut_vec(0)), 64'(0));

        // byte_valid while idle has no effect
        bv = 1'b1;
        bi = 8'h55;
        repeat (4) tick();
        bv = 1'b0;
        chk("idle_ready_busy", {62'(0), ifa.byte_ready, ifa.busy}, 64'(0));
        chk("idle_no_word", 64'(vcnt[0]), 64'(0));

        // WORDS=1 frame
        pulse_start();
        send_word(8'hBE, 8'hEF, 8'h92, 0);
        chk("w1_word", {ifa.word_valid, ifa.word_data, ifa.word_crc_ok, ifa.frame_done, ifa.crc_err_cnt},
            {1'b1, 16'hBEEF, 1'b1, 1'b1, 8'd0});
        tick();
        chk("w1_busy_drop", 64'(ifa.busy), 64'(0));

        // WORDS=2 frame on instance b
        pulse_start();
        send_word(8'hBE, 8'hEF, 8'h92, 1);
        chk("w2_first", {ifb.word_valid, ifb.word_data, ifb.word_crc_ok, ifb.frame_done},
            {1'b1, 16'hBEEF, 1'b1, 1'b0});
        send_word(8'h00, 8'h00, 8'h81, 1);
        chk("w2_second", {ifb.word_valid, ifb.word_data, ifb.word_crc_ok, ifb.frame_done},
            {1'b1, 16'h0000, 1'b1, 1'b1});

        // Bad CRC
        pulse_start();
        send_word(8'hBE, 8'hEF, 8'h93, 0);
        chk("bad_word", {ifa.word_valid, ifa.word_crc_ok, ifa.crc_err_cnt}, {1'b1, 1'b0, 8'd1});

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            pulse_start();
            send_word(vt[i].b0, vt[i].b1, vt[i].c, 0);
            chk($sformatf("table%0d", i), {ifa.word_valid, ifa.word_data, ifa.word_crc_ok},
                {1'b1, vt[i].data, vt[i].ok});
        end

        // byte_valid held high: acceptances spaced by the 9-cycle shift window
        gap_bytes[0] = 8'hBE; gap_bytes[1] = 8'hEF; gap_bytes[2] = 8'h92;
        pulse_start();
        idx = 0;
        bv  = 1'b1;
        for (int c = 0; c < 60 && idx < 3; c++) begin
            logic was;
            bi  = gap_bytes[idx];
            was = ifa.byte_ready;
            tick();
            if (was) begin
                t_acc[idx] = c;
                idx++;
            end
        end
        bv = 1'b0;
        chk("gap_all_accepted", 64'(idx), 64'(3));
        chk("gap_0_1", 64'(t_acc[1] - t_acc[0]), 64'(9));
        chk("gap_1_2", 64'(t_acc[2] - t_acc[1]), 64'(9));
        chk("gap_word", {ifa.word_valid, ifa.word_data, ifa.word_crc_ok}, {1'b1, 16'hBEEF, 1'b1});

        // Abort mid-word: only the restarted word is reported
        v0 = vcnt[0];
        pulse_start();
        send_byte(8'hBE, 0);
        tick();
        pulse_start();
        send_word(8'hBE, 8'hEF, 8'h92, 0);
        chk("abort_count", 64'(vcnt[0] - v0), 64'(1));
        chk("abort_ok", {ifa.word_data, ifa.word_crc_ok}, {16'hBEEF, 1'b1});

        // start coincident with byte_valid drops the byte
        pulse_start();
        tick();
        start = 1'b1; bv = 1'b1; bi = 8'h00;
        tick();
        start = 1'b0; bv = 1'b0;
        send_word(8'hBE, 8'hEF, 8'h92, 0);
        chk("coincident_drop", {ifa.word_data, ifa.word_crc_ok}, {16'hBEEF, 1'b1});

        // Reset in the middle of SHIFT
        pulse_start();
        send_byte(8'hBE, 0);
        tick();
        tick();
        rst = 1'b0;
        v0  = vcnt[0];
        tick();
        chk("rst_midshift_a", 64'(dut_vec(0)), 64'(0));
        chk("rst_midshift_b", 64'(dut_vec(1)), 64'(0));
        rst = 1'b1;
        repeat (12) tick();
        chk("rst_no_partial", 64'(vcnt[0] - v0), 64'(0));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 49) == 0);
            bv    = $urandom_range(0, 1);
            bi    = 8'($urandom);
            if (m_n[1] == 2 && $urandom_range(0, 1) == 1) bi = crc8_ref(m_b[1][0], m_b[1][1]);
            rst   = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1'b1; start = 1'b0; bv = 1'b0;
        tick();

        // Error counter saturation
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            pulse_start();
            send_word(8'hBE, 8'hEF, 8'h93, 0);
        end
        chk("err_saturate", 64'(ifa.crc_err_cnt), 64'(255));
        pulse_start();
        send_word(8'hBE, 8'hEF, 8'h92, 0);
        chk("err_hold_after_ok", {ifa.word_crc_ok, ifa.crc_err_cnt}, {1'b1, 8'd255});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
